direction_uart_tx: RTL and testbench

//   Consumer end of the joystick direction code from main_control.

---
 rtl/dir_pkg.sv | 33 +++
 rtl/uart_tx_byte.sv | 116 +++++++++++
 rtl/direction_uart_tx.sv | 126 ++++++++++++
 tb/tb_direction_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dir_pkg.sv
// Shared joystick direction codes, their ASCII report characters and FSM state types.
package dir_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_FWD   = 4'b0011;
  localparam logic [3:0] DIR_BACK  = 4'b0110;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [0:0] {RPT_IDLE, RPT_SEND} rpt_state_t;

  function automatic logic [7:0] dir_to_ascii(input logic [3:0] code);
    logic [7:0] ch;
    case (code)
      DIR_NONE:  ch = 8'h53;
      DIR_RIGHT: ch = 8'h52;
      DIR_LEFT:  ch = 8'h4C;
      DIR_UP:    ch = 8'h55;
      DIR_DOWN:  ch = 8'h44;
      DIR_FWD:   ch = 8'h46;
      DIR_BACK:  ch = 8'h42;
      default:   ch = 8'h3F;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. A new start is accepted in the last stop-bit
// cycle so consecutive frames run back-to-back.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  import dir_pkg::*;

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_t     state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    data_r, data_s;
  logic          tx_r, tx_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          wrap_s;

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

  // Serializer state register; reset parks the line high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= TX_IDLE;
      timer_r   <= '0;
      bit_idx_r <= 3'd0;
      data_r    <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      bit_idx_r <= bit_idx_s;
      data_r    <= data_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  // Next-state, bit timing and line value.
  always_comb begin
    state_s   = state_r;
    bit_idx_s = bit_idx_r;
    data_s    = data_r;
    tx_s      = tx_r;
    wrap_s    = (timer_r == LAST);
    timer_s   = wrap_s ? '0 : timer_r + TW'(1);
    case (state_r)
      TX_IDLE: begin
        timer_s = '0;
        if (start) begin
          state_s   = TX_START;
          data_s    = data;
          bit_idx_s = 3'd0;
          tx_s      = 1'b0;
        end else begin
          tx_s = 1'b1;
        end
      end
      TX_START: begin
        if (wrap_s) begin
          state_s   = TX_DATA;
          bit_idx_s = 3'd0;
          tx_s      = data_r[0];
        end else begin
          tx_s = 1'b0;
        end
      end
      TX_DATA: begin
        if (wrap_s && (bit_idx_r == 3'd7)) begin
          state_s = TX_STOP;
          tx_s    = 1'b1;
        end else if (wrap_s) begin
          bit_idx_s = bit_idx_r + 3'd1;
          tx_s      = data_r[bit_idx_s];
        end else begin
          tx_s = data_r[bit_idx_r];
        end
      end
      TX_STOP: begin
        if (wrap_s && start) begin
          state_s   = TX_START;
          data_s    = data;
          bit_idx_s = 3'd0;
          tx_s      = 1'b0;
        end else if (wrap_s) begin
          state_s = TX_IDLE;
          tx_s    = 1'b1;
        end else begin
          tx_s = 1'b1;
        end
      end
      default: begin
        state_s = TX_IDLE;
        tx_s    = 1'b1;
      end
    endcase
    busy_s = (state_s != TX_IDLE);
    // done is high exactly during the final stop-bit cycle.
    done_s = (state_s == TX_STOP) && (timer_s == LAST);
  end

endmodule

// File: rtl/direction_uart_tx.sv
// Reports each new joystick direction as one ASCII character over UART, rate-limited
// by a holdoff. Define DIR_UART_CRLF_EN to follow every character with CR and LF.
module direction_uart_tx #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int HOLDOFF_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] direction,
  output logic       tx,
  output logic       busy,
  output logic [3:0] last_sent
);
  import dir_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(HOLDOFF_CYCLES);

  rpt_state_t    state_r, state_s;
  logic [3:0]    dir_q_r;
  logic [3:0]    last_sent_r, last_sent_s;
  logic [HW-1:0] holdoff_r, holdoff_s;
  logic          busy_r, busy_s;
  logic          start_s;
  logic [7:0]    byte_s;
  logic          ser_tx_s, ser_busy_s, ser_done_s;
`ifdef DIR_UART_CRLF_EN
  logic [1:0]    phase_r, phase_s;
`endif

  assign tx        = ser_tx_s;
  assign busy      = busy_r;
  assign last_sent = last_sent_r;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .data  (byte_s),
    .tx    (ser_tx_s),
    .busy  (ser_busy_s),
    .done  (ser_done_s)
  );

  // Direction sampling and report state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= RPT_IDLE;
      dir_q_r     <= 4'b0000;
      last_sent_r <= 4'b0000;
      holdoff_r   <= '0;
      busy_r      <= 1'b0;
`ifdef DIR_UART_CRLF_EN
      phase_r     <= 2'd0;
`endif
    end else begin
      state_r     <= state_s;
      dir_q_r     <= direction;
      last_sent_r <= last_sent_s;
      holdoff_r   <= holdoff_s;
      busy_r      <= busy_s;
`ifdef DIR_UART_CRLF_EN
      phase_r     <= phase_s;
`endif
    end
  end

  // Change detect, holdoff countdown and character sequencing.
  always_comb begin
    state_s     = state_r;
    last_sent_s = last_sent_r;
    holdoff_s   = holdoff_r;
    busy_s      = busy_r;
    start_s     = 1'b0;
    byte_s      = dir_to_ascii(dir_q_r);
`ifdef DIR_UART_CRLF_EN
    phase_s     = phase_r;
`endif
    case (state_r)
      RPT_IDLE: begin
        holdoff_s = (holdoff_r == '0) ? '0 : holdoff_r - HW'(1);
        if ((dir_q_r != last_sent_r) && (holdoff_r == '0) && !ser_busy_s) begin
          start_s     = 1'b1;
          state_s     = RPT_SEND;
          busy_s      = 1'b1;
          last_sent_s = dir_q_r;
`ifdef DIR_UART_CRLF_EN
          phase_s     = 2'd0;
`endif
        end else begin
          state_s = RPT_IDLE;
        end
      end
      RPT_SEND: begin
`ifdef DIR_UART_CRLF_EN
        if (ser_done_s && (phase_r != 2'd2)) begin
          start_s = 1'b1;
          phase_s = phase_r + 2'd1;
          byte_s  = (phase_r == 2'd0) ? ASCII_CR : ASCII_LF;
        end else if (ser_done_s) begin
          state_s   = RPT_IDLE;
          busy_s    = 1'b0;
          holdoff_s = HOLDOFF_LOAD;
        end else begin
          state_s = RPT_SEND;
        end
`else
        if (ser_done_s) begin
          state_s   = RPT_IDLE;
          busy_s    = 1'b0;
          holdoff_s = HOLDOFF_LOAD;
        end else begin
          state_s = RPT_SEND;
        end
`endif
      end
      default: begin
        state_s = RPT_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_direction_uart_tx.sv
// Scoreboard bench: stimulus queues expected characters, a UART line monitor decodes
// and checks every frame. Define DIR_UART_CRLF_EN to exercise CR/LF groups.
module tb_direction_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] direction = 4'b0000;
  logic       tx, busy;
  logic [3:0] last_sent;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] ch;
    logic [3:0] ls;
  } exp_t;
  exp_t exp_q[$];

`ifdef DIR_UART_CRLF_EN
  localparam int GROUP = 3;
`else
  localparam int GROUP = 1;
`endif

  always #5 clk = ~clk;

  direction_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .HOLDOFF_CYCLES(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .direction (direction),
    .tx        (tx),
    .busy      (busy),
    .last_sent (last_sent)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_report(input logic [3:0] code, input logic [7:0] ch);
    exp_q.push_back({ch, code});
`ifdef DIR_UART_CRLF_EN
    exp_q.push_back({8'h0D, code});
    exp_q.push_back({8'h0A, code});
`endif
  endtask

  // Change direction just after an edge: tx must still be high one edge later, low two edges later.
  task automatic drive_and_check_latency(input logic [3:0] code, input string name);
    @(negedge clk);
    direction = code;
    @(negedge clk);
    check({name, "_pre_start"}, {31'd0, tx}, 32'd1);
    @(negedge clk);
    check({name, "_start_bit"}, {31'd0, tx}, 32'd0);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL wait_quiet actual=pending%0d required=0", exp_q.size());
    end
    repeat (40) @(negedge clk);
  endtask

  // Line monitor: sample each bit mid-period, compare against the scoreboard head.
  initial begin : monitor
    bit         in_frame;
    bit         frame_ok;
    int         cnt;
    logic [7:0] sh;
    exp_t       e;
    in_frame = 1'b0;
    frame_ok = 1'b1;
    cnt = 0;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          frame_ok = 1'b1;
          cnt = 0;
          sh = 8'h00;
        end
      end else begin
        cnt++;
        if (busy !== 1'b1) frame_ok = 1'b0;
        if (cnt == 4 && tx !== 1'b0) frame_ok = 1'b0;
        if (cnt >= 14 && cnt <= 84 && ((cnt - 14) % 10) == 0) sh[(cnt - 14) / 10] = tx;
        if (cnt == 94) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=%02h required=none", sh);
          end else begin
            e = exp_q.pop_front();
            check("frame_char", {24'd0, sh}, {24'd0, e.ch});
            check("frame_stop_bit", {31'd0, tx}, 32'd1);
            check("frame_start_busy", {31'd0, frame_ok}, 32'd1);
            check("frame_last_sent", {28'd0, last_sent}, {28'd0, e.ls});
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit ok;
    // Reset state and long idle with unchanged direction
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_last_sent", {28'd0, last_sent}, 32'd0);
    reset = 1'b0;
    ok = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check("idle_500", {31'd0, ok}, 32'd1);
    check("idle_last_sent", {28'd0, last_sent}, 32'd0);

    // 'R' frame; during it go LEFT and back to RIGHT: nothing further is sent
    expect_report(4'b1000, 8'h52);
    drive_and_check_latency(4'b1000, "r");
    check("r_last_sent", {28'd0, last_sent}, 32'h8);
    repeat (30) @(negedge clk);
    direction = 4'b0100;
    repeat (20) @(negedge clk);
    direction = 4'b1000;
    wait_quiet();
    ok = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
    check("aba_no_frame", {31'd0, ok}, 32'd1);
    check("aba_last_sent", {28'd0, last_sent}, 32'h8);

    // Only the latest code of UP then FWD during an 'R' frame is reported
    expect_report(4'b0000, 8'h53);
    drive_and_check_latency(4'b0000, "s");
    wait_quiet();
    expect_report(4'b1000, 8'h52);
    drive_and_check_latency(4'b1000, "r2");
    repeat (30) @(negedge clk);
    direction = 4'b0001;
    repeat (30) @(negedge clk);
    direction = 4'b0011;
    expect_report(4'b0011, 8'h46);
    wait_quiet();
    check("f_last_sent", {28'd0, last_sent}, 32'h3);

    // Unmapped code
    expect_report(4'b1111, 8'h3F);
    drive_and_check_latency(4'b1111, "q");
    wait_quiet();
    check("q_last_sent", {28'd0, last_sent}, 32'hF);

    // Reset mid-DATA acts without a clock edge; frame restarts two cycles after release
    drive_and_check_latency(4'b0010, "abort");
    repeat (35) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_last_sent", {28'd0, last_sent}, 32'd0);
    direction = 4'b0011;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_report(4'b0011, 8'h46);
    @(negedge clk);
    check("post_rst_pre_start", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("post_rst_start_bit", {31'd0, tx}, 32'd0);
    wait_quiet();

    // 0000 -> 0010: 'D' report; busy spans the whole frame group
    expect_report(4'b0000, 8'h53);
    drive_and_check_latency(4'b0000, "s2");
    wait_quiet();
    expect_report(4'b0010, 8'h44);
    drive_and_check_latency(4'b0010, "d");
    ok = 1'b1;
    repeat (GROUP * 100 - 1) begin
      @(negedge clk);
      if (busy !== 1'b1) ok = 1'b0;
    end
    check("d_busy_group", {31'd0, ok}, 32'd1);
    @(negedge clk);
    check("d_busy_release", {31'd0, busy}, 32'd0);
    wait_quiet();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
